ysyx_23060077_icache_axi_rd: RTL and testbench

Burst-read bridge between the instruction cache refill port and the SoC AXI4 read channels. It accepts one line-refill request (address, beat count) from the ICache and issues a single INCR AR transaction. It then returns each 32-bit word to the ICache as a one-cycle strobe, with a last flag and an error flag on the final word. The block sits directly downstream of the ICache refill interface and upstream of the AXI crossbar.

---
 rtl/ysyx_23060077_icache_axi_rd.sv | 156 +++++++++++++++
 tb/tb_ysyx_23060077_icache_axi_rd.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060077_icache_axi_rd.sv
// ICache refill bridge: one INCR AR burst per line refill, each returned 32-bit
// word is forwarded as a one-cycle strobe; the final strobe carries last/err.
module ysyx_23060077_icache_axi_rd #(
  parameter int          AXI_DATA_WIDTH = 64,
  parameter int          AXI_ID_WIDTH   = 4,
  parameter int unsigned ARID           = 0
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      req_valid_i,
  input  logic [31:0]               req_addr_i,
  input  logic [7:0]                req_len_i,
  output logic                      rsp_ready_o,
  output logic [31:0]               rsp_data_o,
  output logic                      rsp_last_o,
  output logic                      rsp_err_o,
  output logic                      arvalid_o,
  input  logic                      arready_i,
  output logic [31:0]               araddr_o,
  output logic [AXI_ID_WIDTH-1:0]   arid_o,
  output logic [7:0]                arlen_o,
  output logic [2:0]                arsize_o,
  output logic [1:0]                arburst_o,
  input  logic                      rvalid_i,
  output logic                      rready_o,
  input  logic [AXI_DATA_WIDTH-1:0] rdata_i,
  input  logic [1:0]                rresp_i,
  input  logic                      rlast_i,
  input  logic [AXI_ID_WIDTH-1:0]   rid_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    R    = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] beat_addr_q, beat_addr_d;
  logic [7:0]  beat_cnt_q, beat_cnt_d;
  logic        err_q, err_d;
  logic [31:0] araddr_q, araddr_d;
  logic [7:0]  arlen_q, arlen_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;
  logic        rsp_ready_q, rsp_ready_d;
  logic        rsp_last_q, rsp_last_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        r_hs;
  logic        unused_rid;

  // The ID is constant and only one burst is ever outstanding, so rid is not needed.
  assign unused_rid = ^rid_i;
  assign r_hs       = rvalid_i & rready_q;

  always_comb begin
    state_d     = state_q;
    beat_addr_d = beat_addr_q;
    beat_cnt_d  = beat_cnt_q;
    err_d       = err_q;
    araddr_d    = araddr_q;
    arlen_d     = arlen_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_data_d  = rsp_data_q;
    rsp_ready_d = 1'b0;
    rsp_last_d  = 1'b0;
    rsp_err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          beat_addr_d = req_addr_i;
          araddr_d    = req_addr_i;
          arlen_d     = req_len_i;
          err_d       = 1'b0;
          beat_cnt_d  = 8'd0;
          arvalid_d   = 1'b1;
          state_d     = AR;
        end
      end
      AR: begin
        if (arready_i) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = R;
        end
      end
      R: begin
        if (r_hs) begin
          rsp_data_d  = beat_addr_q[2] ? rdata_i[63:32] : rdata_i[31:0];
          rsp_ready_d = 1'b1;
          beat_addr_d = beat_addr_q + 32'd4;
          beat_cnt_d  = beat_cnt_q + 8'd1;
          err_d       = err_q | (rresp_i != 2'b00);
          // Only rlast ends the burst; beat_cnt is informational.
          if (rlast_i) begin
            rready_d   = 1'b0;
            rsp_last_d = 1'b1;
            rsp_err_d  = err_q | (rresp_i != 2'b00);
            state_d    = DONE;
          end
        end
      end
      DONE: begin
        // The ICache still holds req_valid here; ignoring it avoids a duplicate refill.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      beat_addr_q <= 32'd0;
      beat_cnt_q  <= 8'd0;
      err_q       <= 1'b0;
      araddr_q    <= 32'd0;
      arlen_q     <= 8'd0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_data_q  <= 32'd0;
      rsp_ready_q <= 1'b0;
      rsp_last_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_addr_q <= beat_addr_d;
      beat_cnt_q  <= beat_cnt_d;
      err_q       <= err_d;
      araddr_q    <= araddr_d;
      arlen_q     <= arlen_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_data_q  <= rsp_data_d;
      rsp_ready_q <= rsp_ready_d;
      rsp_last_q  <= rsp_last_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign rsp_ready_o = rsp_ready_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_last_o  = rsp_last_q;
  assign rsp_err_o   = rsp_err_q;
  assign arvalid_o   = arvalid_q;
  assign araddr_o    = araddr_q;
  assign arlen_o     = arlen_q;
  assign arid_o      = AXI_ID_WIDTH'(ARID);
  assign arsize_o    = 3'b010;
  assign arburst_o   = 2'b01;
  assign rready_o    = rready_q;

endmodule

// File: tb/tb_ysyx_23060077_icache_axi_rd.sv
// Directed bench for the ICache refill bridge: drives the AXI slave side
// cycle by cycle and checks every strobe against hand-derived words.
module tb_ysyx_23060077_icache_axi_rd;

  logic        clock;
  logic        reset;
  logic        req_valid_i;
  logic [31:0] req_addr_i;
  logic [7:0]  req_len_i;
  logic        rsp_ready_o;
  logic [31:0] rsp_data_o;
  logic        rsp_last_o;
  logic        rsp_err_o;
  logic        arvalid_o;
  logic        arready_i;
  logic [31:0] araddr_o;
  logic [3:0]  arid_o;
  logic [7:0]  arlen_o;
  logic [2:0]  arsize_o;
  logic [1:0]  arburst_o;
  logic        rvalid_i;
  logic        rready_o;
  logic [63:0] rdata_i;
  logic [1:0]  rresp_i;
  logic        rlast_i;
  logic [3:0]  rid_i;

  int          n_checks;
  int          n_errors;
  int          cyc;
  int          last_cycles;
  logic [63:0] rdata_tbl [8];
  logic [31:0] obs_words [8];
  logic [31:0] exp_zero_wait [4];

  ysyx_23060077_icache_axi_rd dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid_i(req_valid_i),
    .req_addr_i (req_addr_i),
    .req_len_i  (req_len_i),
    .rsp_ready_o(rsp_ready_o),
    .rsp_data_o (rsp_data_o),
    .rsp_last_o (rsp_last_o),
    .rsp_err_o  (rsp_err_o),
    .arvalid_o  (arvalid_o),
    .arready_i  (arready_i),
    .araddr_o   (araddr_o),
    .arid_o     (arid_o),
    .arlen_o    (arlen_o),
    .arsize_o   (arsize_o),
    .arburst_o  (arburst_o),
    .rvalid_i   (rvalid_i),
    .rready_o   (rready_o),
    .rdata_i    (rdata_i),
    .rresp_i    (rresp_i),
    .rlast_i    (rlast_i),
    .rid_i      (rid_i)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Advance one clock and sample 1 ns after the rising edge.
  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
    check("ar_r_exclusive", 64'(arvalid_o & rready_o), 64'd0);
  endtask

  task automatic check_reset_values();
    check("rst_arvalid", 64'(arvalid_o), 64'd0);
    check("rst_rready", 64'(rready_o), 64'd0);
    check("rst_rsp_ready", 64'(rsp_ready_o), 64'd0);
    check("rst_rsp_last", 64'(rsp_last_o), 64'd0);
    check("rst_rsp_err", 64'(rsp_err_o), 64'd0);
    check("rst_rsp_data", 64'(rsp_data_o), 64'd0);
    check("rst_araddr", 64'(araddr_o), 64'd0);
    check("rst_arlen", 64'(arlen_o), 64'd0);
    check("rst_arsize", 64'(arsize_o), 64'd2);
    check("rst_arburst", 64'(arburst_o), 64'd1);
    check("rst_arid", 64'(arid_o), 64'd0);
  endtask

  // One complete refill; nbeats is where the slave asserts rlast.
  task automatic do_refill(input logic [31:0] addr, input logic [7:0] len, input int nbeats,
                           input int ar_wait, input int gap, input int err_beat);
    logic [31:0] a;
    logic [31:0] exp_w;
    logic        e;
    logic        last;
    int          t;
    a = addr;
    e = 1'b0;
    t = cyc;
    req_valid_i = 1'b1;
    req_addr_i  = addr;
    req_len_i   = len;
    step();
    check("ar_valid", 64'(arvalid_o), 64'd1);
    check("ar_addr", 64'(araddr_o), 64'(addr));
    check("ar_len", 64'(arlen_o), 64'(len));
    check("ar_no_rready", 64'(rready_o), 64'd0);
    for (int w = 0; w < ar_wait; w++) begin
      arready_i = 1'b0;
      step();
      check("ar_hold_valid", 64'(arvalid_o), 64'd1);
      check("ar_hold_addr", 64'(araddr_o), 64'(addr));
    end
    arready_i = 1'b1;
    step();
    arready_i = 1'b0;
    check("ar_drop", 64'(arvalid_o), 64'd0);
    for (int i = 0; i < nbeats; i++) begin
      last = (i == nbeats - 1);
      check("r_ready", 64'(rready_o), 64'd1);
      rvalid_i = 1'b1;
      rdata_i  = rdata_tbl[i];
      rresp_i  = (i == err_beat) ? 2'b10 : 2'b00;
      rlast_i  = last;
      if (i == err_beat) e = 1'b1;
      exp_w = a[2] ? rdata_tbl[i][63:32] : rdata_tbl[i][31:0];
      step();
      rvalid_i = 1'b0;
      rlast_i  = 1'b0;
      rresp_i  = 2'b00;
      check("rsp_strobe", 64'(rsp_ready_o), 64'd1);
      check("rsp_data", 64'(rsp_data_o), 64'(exp_w));
      check("rsp_last", 64'(rsp_last_o), 64'(last));
      check("rsp_err", 64'(rsp_err_o), 64'(last & e));
      obs_words[i] = rsp_data_o;
      a = a + 32'd4;
      if (!last) begin
        for (int g = 0; g < gap; g++) begin
          step();
          check("gap_no_strobe", 64'(rsp_ready_o), 64'd0);
          check("gap_data_hold", 64'(rsp_data_o), 64'(exp_w));
        end
      end
    end
    last_cycles = cyc - t;
    // req_valid stays high through the final-strobe cycle, dropped once back in IDLE.
    step();
    req_valid_i = 1'b0;
    check("idle_no_strobe", 64'(rsp_ready_o), 64'd0);
    check("idle_no_last", 64'(rsp_last_o), 64'd0);
    check("idle_rready", 64'(rready_o), 64'd0);
    check("idle_arvalid", 64'(arvalid_o), 64'd0);
    step();
    check("no_reissue", 64'(arvalid_o), 64'd0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    cyc = 0;
    rdata_tbl[0] = 64'h1111_1111_0000_0000;
    rdata_tbl[1] = 64'h2222_2222_3333_3333;
    rdata_tbl[2] = 64'h4444_4444_5555_5555;
    rdata_tbl[3] = 64'h6666_6666_7777_7777;
    rdata_tbl[4] = 64'h8888_8888_9999_9999;
    rdata_tbl[5] = 64'hAAAA_AAAA_BBBB_BBBB;
    rdata_tbl[6] = 64'hCCCC_CCCC_DDDD_DDDD;
    rdata_tbl[7] = 64'hEEEE_EEEE_FFFF_FFFF;
    exp_zero_wait[0] = 32'h0000_0000;
    exp_zero_wait[1] = 32'h2222_2222;
    exp_zero_wait[2] = 32'h5555_5555;
    exp_zero_wait[3] = 32'h6666_6666;

    reset = 1'b1;
    req_valid_i = 1'b0;
    req_addr_i = 32'd0;
    req_len_i = 8'd0;
    arready_i = 1'b0;
    rvalid_i = 1'b0;
    rdata_i = 64'd0;
    rresp_i = 2'b00;
    rlast_i = 1'b0;
    rid_i = 4'd0;
    repeat (3) step();
    check_reset_values();
    reset = 1'b0;
    step();

    // Zero-wait refill: lanes lo, hi, lo, hi; last strobe at t+6.
    do_refill(32'h3000_0010, 8'd3, 4, 0, 0, -1);
    check("zw_last_cycle", 64'(last_cycles), 64'd6);
    for (int i = 0; i < 4; i++) check("zw_word", 64'(obs_words[i]), 64'(exp_zero_wait[i]));

    // Backpressure: AR stalled 5 cycles, 2-cycle rvalid gaps, hi-lane start.
    do_refill(32'h3000_0104, 8'd3, 4, 5, 2, -1);

    // Error on beat 1 only, then a clean refill must report no error.
    do_refill(32'h8000_0000, 8'd3, 4, 0, 1, 1);
    do_refill(32'h8000_0020, 8'd3, 4, 0, 0, -1);

    // Idle gap with request low: nothing issued until a new request.
    repeat (2) begin
      step();
      check("idle_quiet", 64'(arvalid_o), 64'd0);
    end

    // Reset after beat 2 of a burst.
    req_valid_i = 1'b1;
    req_addr_i  = 32'h4000_0000;
    req_len_i   = 8'd3;
    step();
    arready_i = 1'b1;
    step();
    arready_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rvalid_i = 1'b1;
      rdata_i  = rdata_tbl[i];
      step();
    end
    rvalid_i = 1'b0;
    reset = 1'b1;
    step();
    check_reset_values();
    reset = 1'b0;
    req_valid_i = 1'b0;
    step();
    check("post_rst_idle", 64'(arvalid_o), 64'd0);
    do_refill(32'h4000_0008, 8'd3, 4, 1, 0, -1);

    // Early rlast on beat 2 with arlen=3.
    do_refill(32'h3000_0040, 8'd3, 2, 0, 0, -1);

    // Longer 8-beat burst with waits and an error on the final beat.
    do_refill(32'h5000_000C, 8'd7, 8, 2, 1, 7);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
